// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID and ID/EX pipeline registers.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FLUSH_CYC  = 1,
    parameter int MEM_TMO    = 64,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_rs1_ren,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs2_ren,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  ex_valid,
    input  logic                  ex_mem_ren,
    input  logic [REG_ADDR_W-1:0] ex_reg_waddr,
    input  logic                  branch_en,
    input  logic                  jump_en,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_hold,
    output logic                  mem_tmo_err,
    output logic [1:0]            state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_UNUSED = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    if (FLUSH_CYC < 1 || FLUSH_CYC > 15 || MEM_TMO < 2 || MEM_TMO > 255 || CNT_W < 1) begin : g_param_err
        $error("pipe_hazard_ctrl: parameter out of legal range");
    end

    // fcnt holds the number of flush cycles still owed after the current one.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);
    localparam logic [7:0] TMO_LAST   = 8'(MEM_TMO - 1);
    localparam state_t     REDIR_NEXT = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;

    state_t     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic [7:0] tcnt_q, tcnt_d;

    logic redir;
    logic lu;
    logic redir_acc;
    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_en_c, idex_hold_c, tmo_err_c;

    assign redir = branch_en | jump_en;
    assign lu    = ex_valid & ex_mem_ren & (ex_reg_waddr != '0) & id_valid &
                   ((id_rs1_ren & (id_rs1_addr == ex_reg_waddr)) |
                    (id_rs2_ren & (id_rs2_addr == ex_reg_waddr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        tcnt_d       = tcnt_q;
        redir_acc    = 1'b0;
        pc_stall_c   = 1'b0;
        ifid_stall_c = 1'b0;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b0;
        idex_hold_c  = 1'b0;
        tmo_err_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                idex_en_c = id_valid;
                if (redir) begin
                    ifid_flush_c = 1'b1;
                    idex_en_c    = 1'b0;
                    fcnt_d       = FLUSH_LOAD;
                    state_d      = REDIR_NEXT;
                    redir_acc    = 1'b1;
                end else if (mem_req && !mem_ack) begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_hold_c  = 1'b1;
                    idex_en_c    = 1'b0;
                    tcnt_d       = 8'd1;
                    state_d      = ST_WAIT;
                end else if (!mem_req && lu) begin
                    // One bubble suffices: the load leaves EX on the next edge.
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_en_c    = 1'b0;
                end
            end
            ST_WAIT: begin
                // Redirects are ignored here; the EX instruction is frozen.
                if (mem_ack) begin
                    idex_en_c = id_valid;
                    tcnt_d    = '0;
                    state_d   = ST_RUN;
                end else begin
                    pc_stall_c   = 1'b1;
                    ifid_stall_c = 1'b1;
                    idex_hold_c  = 1'b1;
                    if (tcnt_q == TMO_LAST) begin
                        tmo_err_c = 1'b1;
                        tcnt_d    = '0;
                        state_d   = ST_RUN;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            ST_FLUSH: begin
                ifid_flush_c = 1'b1;
                if (redir) begin
                    fcnt_d    = FLUSH_LOAD;
                    state_d   = REDIR_NEXT;
                    redir_acc = 1'b1;
                end else if (fcnt_q <= 4'd1) begin
                    fcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // All outputs are forced low while reset is asserted.
    assign pc_stall    = rst_n & pc_stall_c;
    assign ifid_stall  = rst_n & ifid_stall_c;
    assign ifid_flush  = rst_n & ifid_flush_c;
    assign idex_en     = rst_n & idex_en_c;
    assign idex_hold   = rst_n & idex_hold_c;
    assign mem_tmo_err = rst_n & tmo_err_c;
    assign state       = rst_n ? state_q : 2'd0;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redir_acc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = rst_n ? stall_cnt_q : '0;
    assign perf_flush_cnt = rst_n ? flush_cnt_q : '0;
`endif

endmodule
